// File: rtl/branch_predict_unit.sv
// Branch resolution for RV32 conditional branches and jal/jalr, plus a direct-mapped
// table of 2-bit saturating counters for fetch-stage prediction. Optional statistics: BRANCH_STATS_EN.
module branch_predict_unit #(
  parameter int         XLEN      = 32,
  parameter int         BHT_IDX_W = 4,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  input  logic            resolve_valid,
  input  logic [XLEN-1:0] resolve_pc,
  input  logic [2:0]      func3,
  input  logic            branch,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            pred_was_taken,
  output logic            pc_src,
  output logic            mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
`endif
);

  localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

  logic [1:0]           bht_r [BHT_ENTRIES];
  logic [BHT_IDX_W-1:0] fetch_idx_s;
  logic [BHT_IDX_W-1:0] resolve_idx_s;
  logic                 eq_s;
  logic                 lt_s;
  logic                 ltu_s;
  logic                 cond_s;
  logic                 taken_s;
  logic                 valid_f3_s;
  logic                 cond_br_s;
  logic                 update_s;
  logic                 mispredict_next_s;
  logic [1:0]           ctr_cur_s;
  logic [1:0]           ctr_next_s;
  logic                 unused_s;

  // Word-aligned PCs: the two low bits never select an entry.
  assign fetch_idx_s   = fetch_pc[BHT_IDX_W+1:2];
  assign resolve_idx_s = resolve_pc[BHT_IDX_W+1:2];
  assign unused_s      = ^{fetch_pc[XLEN-1:BHT_IDX_W+2], fetch_pc[1:0],
                           resolve_pc[XLEN-1:BHT_IDX_W+2], resolve_pc[1:0]};

  assign eq_s  = (rs1_data == rs2_data);
  assign lt_s  = ($signed(rs1_data) < $signed(rs2_data));
  assign ltu_s = (rs1_data < rs2_data);

  // Branch condition decode from funct3
  always_comb begin
    cond_s = 1'b0;
    case (func3)
      3'd0:    cond_s = eq_s;
      3'd1:    cond_s = !eq_s;
      3'd4:    cond_s = lt_s;
      3'd5:    cond_s = !lt_s;
      3'd6:    cond_s = ltu_s;
      3'd7:    cond_s = !ltu_s;
      default: cond_s = 1'b0;
    endcase
  end

  assign valid_f3_s        = (func3 != 3'd2) && (func3 != 3'd3);
  assign taken_s           = resolve_valid & branch & cond_s;
  assign cond_br_s         = resolve_valid & branch & !jal & !jalr;
  assign update_s          = cond_br_s & valid_f3_s;
  assign mispredict_next_s = cond_br_s & (taken_s != pred_was_taken);

  assign pc_src     = resolve_valid & (jal | jalr | taken_s);
  assign pred_taken = bht_r[fetch_idx_s][1];
  assign ctr_cur_s  = bht_r[resolve_idx_s];

  // Saturating counter step for the resolving entry
  always_comb begin
    ctr_next_s = ctr_cur_s;
    if (taken_s) begin
      if (ctr_cur_s != 2'b11) ctr_next_s = ctr_cur_s + 2'd1;
      else                    ctr_next_s = ctr_cur_s;
    end else begin
      if (ctr_cur_s != 2'b00) ctr_next_s = ctr_cur_s - 2'd1;
      else                    ctr_next_s = ctr_cur_s;
    end
  end

  // Counter table and registered misprediction pulse; reset wins over an update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_r[i] <= CTR_INIT;
      mispredict <= 1'b0;
    end else begin
      if (update_s) bht_r[resolve_idx_s] <= ctr_next_s;
      mispredict <= mispredict_next_s;
    end
  end

`ifdef BRANCH_STATS_EN
  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      if (update_s)          branch_count     <= branch_count + 32'd1;
      if (mispredict_next_s) mispredict_count <= mispredict_count + 32'd1;
    end
  end
`endif

endmodule
